// File: rtl/wbslv_pkg.sv
// Shared types and helpers for the Wishbone slave register bank.
// Mask helpers take full-width masks so they work for any register count.
package wbslv_pkg;

    localparam int REG_ADDR_W = 8;
    localparam int MAX_REGS   = 1 << REG_ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        RESP,
        WAIT_REL
    } state_e;

    function automatic logic is_ro(input logic [MAX_REGS-1:0]   ro_mask,
                                   input logic [REG_ADDR_W-1:0] idx);
        return ro_mask[idx];
    endfunction

    // Read-only wins when a register is flagged as both read-only and pulse.
    function automatic logic is_pulse(input logic [MAX_REGS-1:0]   ro_mask,
                                      input logic [MAX_REGS-1:0]   pulse_mask,
                                      input logic [REG_ADDR_W-1:0] idx);
        return pulse_mask[idx] & ~ro_mask[idx];
    endfunction

endpackage

// File: rtl/wbslv_decode.sv
// Address decode for the register bank: combinational module hit for the FSM,
// registered register index and access classification for the response cycle.
module wbslv_decode
    import wbslv_pkg::*;
#(
    parameter int              WbAddWidth = 12,
    parameter int              MODULE_ID  = 1,
    parameter int              NREG       = 16,
    parameter logic [NREG-1:0] RO_MASK    = '0,
    parameter logic [NREG-1:0] PULSE_MASK = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  i_cyc,
    input  logic                  i_stb,
    input  logic                  i_we,
    input  logic [WbAddWidth-1:0] i_adr,
    input  logic                  i_capture,
    output logic                  o_hit,
    output logic [REG_ADDR_W-1:0] o_reg_idx,
    output logic                  o_we,
    output logic                  o_is_err,
    output logic                  o_is_ro,
    output logic                  o_is_pulse
);

    localparam int MOD_W = WbAddWidth - REG_ADDR_W;
    localparam logic [MAX_REGS-1:0] RO_MASK_W    = MAX_REGS'(RO_MASK);
    localparam logic [MAX_REGS-1:0] PULSE_MASK_W = MAX_REGS'(PULSE_MASK);

    logic [REG_ADDR_W-1:0] w_idx;
    logic                  w_in_range;
    logic                  w_is_ro;
    logic                  w_is_pulse;
    logic                  w_is_err;

    assign w_idx      = i_adr[REG_ADDR_W-1:0];
    assign w_in_range = int'(w_idx) < NREG;
    assign w_is_ro    = w_in_range & is_ro(RO_MASK_W, w_idx);
    assign w_is_pulse = w_in_range & is_pulse(RO_MASK_W, PULSE_MASK_W, w_idx);
    assign w_is_err   = ~w_in_range | (i_we & w_is_ro);

    assign o_hit = i_cyc & i_stb & (i_adr[WbAddWidth-1:REG_ADDR_W] == MOD_W'(MODULE_ID));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            o_reg_idx  <= '0;
            o_we       <= 1'b0;
            o_is_err   <= 1'b0;
            o_is_ro    <= 1'b0;
            o_is_pulse <= 1'b0;
        end else if (i_capture && o_hit) begin
            o_reg_idx  <= w_idx;
            o_we       <= i_we;
            o_is_err   <= w_is_err;
            o_is_ro    <= w_is_ro;
            o_is_pulse <= w_is_pulse;
        end
    end

endmodule

// File: rtl/wbslv_regbank.sv
// Wishbone slave register bank: RW control, RO status and write-pulse registers
// with a single-cycle ack/err response, one access per strobe assertion.
module wbslv_regbank
    import wbslv_pkg::*;
#(
    parameter int              WbDataWidth = 16,
    parameter int              WbAddWidth  = 12,
    parameter int              MODULE_ID   = 1,
    parameter int              NREG        = 16,
    parameter logic [NREG-1:0] RO_MASK     = '0,
    parameter logic [NREG-1:0] PULSE_MASK  = '0
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        wbs_cyc_i,
    input  logic                        wbs_stb_i,
    input  logic                        wbs_we_i,
    input  logic [WbAddWidth-1:0]       wbs_adr_i,
    input  logic [WbDataWidth-1:0]      wbs_dt_i,
    output logic [WbDataWidth-1:0]      wbs_dt_o,
    output logic                        wbs_ack_o,
    output logic                        wbs_err_o,
    output logic [NREG*WbDataWidth-1:0] ctrl_o,
    input  logic [NREG*WbDataWidth-1:0] status_i,
    output logic [NREG-1:0]             pulse_o,
    output logic [NREG-1:0]             rd_strobe_o
);

    localparam int W = WbDataWidth;

    state_e                r_state;
    logic [W-1:0]          r_wdata;
    logic [W-1:0]          r_status;
    logic [NREG*W-1:0]     r_ctrl;

    logic                  w_hit;
    logic [REG_ADDR_W-1:0] w_reg_idx;
    logic                  w_we;
    logic                  w_is_err;
    logic                  w_is_ro;
    logic                  w_is_pulse;
    logic                  w_capture;
    logic                  w_resp;
    logic                  w_ack;
    logic                  w_wr_commit;
    logic                  w_rd_ok;
    logic [W-1:0]          w_status_sel;
    logic [W-1:0]          w_rw_rdata;

    assign w_capture = (r_state == IDLE);

    wbslv_decode #(
        .WbAddWidth (WbAddWidth),
        .MODULE_ID  (MODULE_ID),
        .NREG       (NREG),
        .RO_MASK    (RO_MASK),
        .PULSE_MASK (PULSE_MASK)
    ) u_decode (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .i_cyc      (wbs_cyc_i),
        .i_stb      (wbs_stb_i),
        .i_we       (wbs_we_i),
        .i_adr      (wbs_adr_i),
        .i_capture  (w_capture),
        .o_hit      (w_hit),
        .o_reg_idx  (w_reg_idx),
        .o_we       (w_we),
        .o_is_err   (w_is_err),
        .o_is_ro    (w_is_ro),
        .o_is_pulse (w_is_pulse)
    );

    // NOTE: every combinational output gets a default before the loop so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_status_sel = '0;
        for (int i = 0; i < NREG; i++) begin
            if (wbs_adr_i[REG_ADDR_W-1:0] == REG_ADDR_W'(i)) begin
                w_status_sel = status_i[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state  <= IDLE;
            r_wdata  <= '0;
            r_status <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hit) begin
                        r_state  <= RESP;
                        r_wdata  <= wbs_dt_i;
                        r_status <= w_status_sel;
                    end
                end
                // A dropped cycle during the response still completes it.
                RESP:     r_state <= wbs_cyc_i ? WAIT_REL : IDLE;
                WAIT_REL: if (!wbs_stb_i || !wbs_cyc_i) r_state <= IDLE;
                default:  r_state <= IDLE;
            endcase
        end
    end

    assign w_resp      = (r_state == RESP);
    assign w_ack       = w_resp & ~w_is_err;
    assign w_wr_commit = w_ack & w_we;
    assign w_rd_ok     = w_ack & ~w_we;

    // NOTE: the register file is reset explicitly because fabric logic must
    // see all-zero controls after reset, including mid-access resets.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ctrl <= '0;
        end else if (w_wr_commit && !w_is_pulse) begin
            for (int i = 0; i < NREG; i++) begin
                if (w_reg_idx == REG_ADDR_W'(i)) begin
                    r_ctrl[i*W +: W] <= r_wdata;
                end
            end
        end
    end

    always_comb begin
        w_rw_rdata  = '0;
        pulse_o     = '0;
        rd_strobe_o = '0;
        for (int i = 0; i < NREG; i++) begin
            if (w_reg_idx == REG_ADDR_W'(i)) begin
                w_rw_rdata     = r_ctrl[i*W +: W];
                pulse_o[i]     = w_wr_commit & w_is_pulse;
                rd_strobe_o[i] = w_rd_ok & w_is_ro;
            end
        end
    end

    // Pulse registers have no storage and read as zero.
    always_comb begin
        wbs_dt_o = '0;
        if (w_rd_ok && !w_is_pulse) begin
            wbs_dt_o = w_is_ro ? r_status : w_rw_rdata;
        end
    end

    assign wbs_ack_o = w_ack;
    assign wbs_err_o = w_resp & w_is_err;
    assign ctrl_o    = r_ctrl;

endmodule

// File: tb/tb_wbslv_regbank.sv
// Directed bench for wbslv_regbank: table of single accesses plus hand-written
// sequences for foreign module, held strobe, cyc drop in RESP and mid-access reset.
module tb_wbslv_regbank;

    localparam int W    = 16;
    localparam int AW   = 12;
    localparam int NREG = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cyc = 1'b0;
    logic            stb = 1'b0;
    logic            we = 1'b0;
    logic [AW-1:0]   adr = '0;
    logic [W-1:0]    dti = '0;
    logic [W-1:0]    dto;
    logic            ack;
    logic            err;
    logic [NREG*W-1:0] ctrl;
    logic [NREG*W-1:0] status = '0;
    logic [NREG-1:0] pulse;
    logic [NREG-1:0] rdstb;

    int checks = 0;
    int failures = 0;

    wbslv_regbank #(
        .WbDataWidth (W),
        .WbAddWidth  (AW),
        .MODULE_ID   (1),
        .NREG        (NREG),
        .RO_MASK     (16'h0088),
        .PULSE_MASK  (16'h00A0)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .wbs_cyc_i   (cyc),
        .wbs_stb_i   (stb),
        .wbs_we_i    (we),
        .wbs_adr_i   (adr),
        .wbs_dt_i    (dti),
        .wbs_dt_o    (dto),
        .wbs_ack_o   (ack),
        .wbs_err_o   (err),
        .ctrl_o      (ctrl),
        .status_i    (status),
        .pulse_o     (pulse),
        .rd_strobe_o (rdstb)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic          wr;
        logic [AW-1:0] a;
        logic [W-1:0]  wd;
        logic          e_ack;
        logic          e_err;
        logic [W-1:0]  e_dt;
        logic [W-1:0]  e_pulse;
        logic [W-1:0]  e_rdstb;
        int            chk_reg;
        logic [W-1:0]  e_ctrl;
    } vec_t;

    vec_t vecs[14];

    // Starts a request at a falling edge and waits a bounded number of cycles
    // for ack or err; lat stays -1 if nothing arrives.
    task automatic access(input logic wr, input logic [AW-1:0] a, input logic [W-1:0] wd,
                          output int lat, output logic g_ack, output logic g_err,
                          output logic [W-1:0] g_dt, output logic [W-1:0] g_pulse,
                          output logic [W-1:0] g_rdstb);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = wr; adr = a; dti = wd;
        lat = -1; g_ack = 1'b0; g_err = 1'b0; g_dt = '0; g_pulse = '0; g_rdstb = '0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (ack || err) begin
                lat = k; g_ack = ack; g_err = err; g_dt = dto; g_pulse = pulse; g_rdstb = rdstb;
                break;
            end
        end
    endtask

    function automatic logic [W-1:0] ctrl_slice(input logic [NREG*W-1:0] c, input int r);
        return c[r*W +: W];
    endfunction

    initial begin
        int            lat;
        logic          g_ack, g_err;
        logic [W-1:0]  g_dt, g_pulse, g_rdstb;
        int            n_resp;

        //          wr    adr      wdata     ack   err   dt        pulse     rdstb    reg  ctrl
        vecs[0]  = '{1'b1, 12'h102, 16'h1234, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 2,  16'h1234};
        vecs[1]  = '{1'b0, 12'h102, 16'h0000, 1'b1, 1'b0, 16'h1234, 16'h0000, 16'h0000, 2,  16'h1234};
        vecs[2]  = '{1'b0, 12'h103, 16'h0000, 1'b1, 1'b0, 16'hBEEF, 16'h0000, 16'h0008, 3,  16'h0000};
        vecs[3]  = '{1'b1, 12'h103, 16'h5555, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 3,  16'h0000};
        vecs[4]  = '{1'b0, 12'h1FF, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 2,  16'h1234};
        vecs[5]  = '{1'b1, 12'h10F, 16'hA5A5, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 15, 16'hA5A5};
        vecs[6]  = '{1'b1, 12'h110, 16'h9999, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 15, 16'hA5A5};
        vecs[7]  = '{1'b1, 12'h105, 16'hDEAD, 1'b1, 1'b0, 16'h0000, 16'h0020, 16'h0000, 5,  16'h0000};
        vecs[8]  = '{1'b0, 12'h105, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 5,  16'h0000};
        vecs[9]  = '{1'b0, 12'h107, 16'h0000, 1'b1, 1'b0, 16'h7777, 16'h0000, 16'h0080, 7,  16'h0000};
        vecs[10] = '{1'b1, 12'h107, 16'h1111, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 7,  16'h0000};
        vecs[11] = '{1'b1, 12'h100, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 0,  16'hFFFF};
        vecs[12] = '{1'b0, 12'h100, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 0,  16'hFFFF};
        vecs[13] = '{1'b1, 12'h102, 16'h0001, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 2,  16'h0001};

        status[3*W +: W] = 16'hBEEF;
        status[7*W +: W] = 16'h7777;

        repeat (3) @(negedge clk);
        check("reset_ack", ack, 1'b0);
        check("reset_err", err, 1'b0);
        check("reset_dt", dto, '0);
        check("reset_ctrl", ctrl, '0);
        check("reset_pulse", pulse, '0);
        check("reset_rdstb", rdstb, '0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            access(vecs[i].wr, vecs[i].a, vecs[i].wd, lat, g_ack, g_err, g_dt, g_pulse, g_rdstb);
            check($sformatf("v%0d_latency", i), lat, 1);
            check($sformatf("v%0d_ack", i), g_ack, vecs[i].e_ack);
            check($sformatf("v%0d_err", i), g_err, vecs[i].e_err);
            check($sformatf("v%0d_dt", i), g_dt, vecs[i].e_dt);
            check($sformatf("v%0d_pulse", i), g_pulse, vecs[i].e_pulse);
            check($sformatf("v%0d_rdstb", i), g_rdstb, vecs[i].e_rdstb);
            @(negedge clk);
            check($sformatf("v%0d_resp_one_cycle", i), {ack, err, pulse, rdstb}, '0);
            check($sformatf("v%0d_dt_idle", i), dto, '0);
            cyc = 1'b0; stb = 1'b0;
            @(negedge clk);
            check($sformatf("v%0d_ctrl", i), ctrl_slice(ctrl, vecs[i].chk_reg), vecs[i].e_ctrl);
        end

        // Foreign module address held for 10 cycles: never answered.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 12'h202;
        n_resp = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ack || err) n_resp++;
        end
        check("foreign_no_resp", n_resp, 0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);

        // Strobe held long after the response: exactly one ack.
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 12'h102;
        n_resp = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ack || err) n_resp++;
        end
        check("held_stb_one_ack", n_resp, 1);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);

        // cyc dropped during RESP: write still commits; status sampled at request.
        access(1'b1, 12'h104, 16'h4444, lat, g_ack, g_err, g_dt, g_pulse, g_rdstb);
        check("cycdrop_ack", g_ack, 1'b1);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        check("cycdrop_ack_gone", ack, 1'b0);
        check("cycdrop_ctrl", ctrl_slice(ctrl, 4), 16'h4444);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 12'h104;
        @(negedge clk);
        check("after_drop_read_ack", ack, 1'b1);
        check("after_drop_read_dt", dto, 16'h4444);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        access(1'b0, 12'h103, 16'h0000, lat, g_ack, g_err, g_dt, g_pulse, g_rdstb);
        status[3*W +: W] = 16'h0BAD;
        #1;
        check("status_sampled_dt", dto, 16'hBEEF);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);

        // Reset asserted in the RESP cycle of a write.
        access(1'b1, 12'h101, 16'hFFFF, lat, g_ack, g_err, g_dt, g_pulse, g_rdstb);
        check("rst_pre_ack", g_ack, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_ack", ack, 1'b0);
        check("rst_mid_err", err, 1'b0);
        check("rst_mid_ctrl", ctrl, '0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_after_ctrl1", ctrl_slice(ctrl, 1), 16'h0000);
        check("rst_after_idle", {ack, err, pulse, rdstb}, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
